// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with programmable baud divisor.
//   clock, reset         : single rising-edge clock, synchronous active-high reset
//   rx_in                : asynchronous serial line, idle high
//   baud_div             : clocks per sample tick (0 behaves as 1)
//   parity_type          : 00/11 none, 01 odd, 10 even
//   stop_bits            : 0 = one stop bit, 1 = two stop bits
//   data_out, frame_err  : received word and {break, framing, parity} status
//   data_valid/ready     : holding-register handshake toward the consumer
//   event_err            : one-clock pulses {overrun, false start}
//   active_flag          : high while a frame is being received
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic [1:0]            parity_type,
  input  logic                  stop_bits,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [2:0]            frame_err,
  output logic [1:0]            event_err,
  output logic                  active_flag
);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int MID = OVERSAMPLE / 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;
  state_t state, state_n;

  logic                  rx_meta, rx_sync, rx_prev;
  logic [DIV_WIDTH-1:0]  div_q, div_eff, tick_cnt;
  logic [1:0]            ptype_q;
  logic                  stop2_q;
  logic [SW-1:0]         samp_cnt;
  logic                  s_a, s_b;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]         bit_idx;
  logic                  stop_idx, perr_q, ferr_q, brk_q, par_bit_q;

  logic tick, in_frame, vote, bit_val, start_det, par_en, exp_par;
  logic false_start, done, stop_low, brk_hit, ferr_now, brk_now;

  assign div_eff   = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
  assign tick      = (tick_cnt == div_eff - DIV_WIDTH'(1));
  assign in_frame  = (state == S_START) || (state == S_DATA) ||
                     (state == S_PARITY) || (state == S_STOP);
  // Third sample is the live synced line; the two earlier ones were captured.
  assign vote      = in_frame && tick && (samp_cnt == SW'(MID + 1));
  assign bit_val   = (s_a & s_b) | (s_a & rx_sync) | (s_b & rx_sync);
  assign start_det = (state == S_IDLE) && rx_prev && !rx_sync;
  assign par_en    = (ptype_q == 2'b01) || (ptype_q == 2'b10);
  assign exp_par   = (ptype_q == 2'b10) ? ^shreg : ~^shreg;
  assign active_flag = in_frame;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    false_start = 1'b0;
    done        = 1'b0;
    stop_low    = (state == S_STOP) && vote && !bit_val;
    // Break is judged at the first stop bit against the assembled word.
    brk_hit     = stop_low && !stop_idx && (shreg == '0) && !par_bit_q;
    ferr_now    = ferr_q | stop_low;
    brk_now     = brk_q | brk_hit;
    case (state)
      S_IDLE:   if (start_det) state_n = S_START;
      S_START:  if (vote) begin
                  if (bit_val) begin
                    false_start = 1'b1;
                    state_n     = S_IDLE;
                  end else state_n = S_DATA;
                end
      S_DATA:   if (vote && bit_idx == BW'(DATA_WIDTH - 1))
                  state_n = par_en ? S_PARITY : S_STOP;
      S_PARITY: if (vote) state_n = S_STOP;
      S_STOP:   if (vote && (stop_idx || !stop2_q)) begin
                  done    = 1'b1;
                  state_n = ferr_now ? S_WAIT_HIGH : S_IDLE;
                end
      S_WAIT_HIGH: if (rx_sync) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      div_q      <= '0;
      ptype_q    <= '0;
      stop2_q    <= 1'b0;
      tick_cnt   <= '0;
      samp_cnt   <= '0;
      s_a        <= 1'b0;
      s_b        <= 1'b0;
      shreg      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      par_bit_q  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= '0;
      event_err  <= '0;
    end else begin
      rx_meta   <= rx_in;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      event_err <= {1'b0, false_start};

      if (start_det) begin
        // Frame config is frozen here; sample timing restarts from the edge.
        div_q     <= baud_div;
        ptype_q   <= parity_type;
        stop2_q   <= stop_bits;
        tick_cnt  <= '0;
        samp_cnt  <= '0;
        bit_idx   <= '0;
        stop_idx  <= 1'b0;
        perr_q    <= 1'b0;
        ferr_q    <= 1'b0;
        brk_q     <= 1'b0;
        par_bit_q <= 1'b0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + DIV_WIDTH'(1);
        if (tick && in_frame) begin
          samp_cnt <= (samp_cnt == SW'(OVERSAMPLE - 1)) ? '0 : samp_cnt + SW'(1);
          if (samp_cnt == SW'(MID - 1)) s_a <= rx_sync;
          if (samp_cnt == SW'(MID))     s_b <= rx_sync;
        end
        if (vote) begin
          case (state)
            S_DATA: begin
              shreg   <= {bit_val, shreg[DATA_WIDTH-1:1]};
              bit_idx <= bit_idx + BW'(1);
            end
            S_PARITY: begin
              par_bit_q <= bit_val;
              perr_q    <= (bit_val != exp_par);
            end
            S_STOP: begin
              stop_idx <= 1'b1;
              if (stop_low) ferr_q <= 1'b1;
              if (brk_hit)  brk_q  <= 1'b1;
            end
            default: ;
          endcase
        end
      end

      // A drain in the completion cycle frees the register for the new word.
      if (done) begin
        if (!data_valid || data_ready) begin
          data_out   <= shreg;
          frame_err  <= {brk_now, ferr_now, perr_q};
          data_valid <= 1'b1;
        end else begin
          event_err[1] <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end
endmodule
